// File: rtl/shift_issue_unit.sv
// -----------------------------------------------------------------------------
// shift_issue_unit
//
// Two-stage pipelined front end for the external combinational shifter.
// S1 registers a decoded shift request and drives the shifter inputs from
// those registers. S2 captures the shifter output along with the zero and
// carry flags, the illegal-op flag and the destination tag for writeback.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   asynchronous, active-low reset
//   flush        in   synchronous kill of both stages
//   in_valid     in   request valid
//   in_ready     out  request can be accepted this cycle
//   op           in   [2:0] 000 shll, 001 shrl, 010 shra,
//                     100 shllv, 101 shrlv, 110 shrav; x11 illegal
//   rs_val       in   [31:0] value to shift
//   rt_val       in   [31:0] variable shift amount (ops 1xx)
//   imm_shamt    in   [4:0] immediate shift amount (ops 0xx)
//   dst          in   [4:0] destination register tag
//   sh_in        out  [31:0] shifter operand
//   sh_shamt     out  [31:0] shifter amount
//   sh_dir       out  shifter direction, 1 = left
//   sh_arith     out  shifter mode, 1 = arithmetic
//   sh_out       in   [31:0] shifter result
//   out_valid    out  result valid
//   out_ready    in   writeback accepts result
//   result       out  [31:0] shifted value
//   out_dst      out  [4:0] tag of result
//   zero_flag    out  result == 0
//   carry_flag   out  last bit shifted out
//   illegal      out  op was 011/111
// -----------------------------------------------------------------------------
module shift_issue_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [4:0]  imm_shamt,
    input  logic [4:0]  dst,
    output logic [31:0] sh_in,
    output logic [31:0] sh_shamt,
    output logic        sh_dir,
    output logic        sh_arith,
    input  logic [31:0] sh_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [4:0]  out_dst,
    output logic        zero_flag,
    output logic        carry_flag,
    output logic        illegal
);

    // ---------------- stage 1 state ----------------
    logic        s1_valid;
    logic [31:0] s1_rs;
    logic [31:0] s1_n;
    logic        s1_dir;
    logic        s1_arith;
    logic        s1_illegal;
    logic [4:0]  s1_dst;

    // ---------------- handshake ----------------
    logic s2_adv;
    logic accept;

    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    // rst gates in_ready so the unit never advertises space while held in reset.
    assign in_ready = rst && !flush && (!s1_valid || s2_adv);
    assign accept   = in_valid && in_ready;

    // ---------------- request decode ----------------
    logic        dec_illegal;
    logic        dec_dir;
    logic        dec_arith;
    logic [31:0] dec_n;

    assign dec_illegal = (op[1:0] == 2'b11);
    assign dec_dir     = (op[1:0] == 2'b00);
    assign dec_arith   = (op[1:0] == 2'b10);
    assign dec_n       = op[2] ? rt_val : {27'b0, imm_shamt};

    // NOTE: data registers are reset as well as the valid bits, because the
    // shifter-facing outputs and the result bus must read 0 out of reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1_rs      <= '0;
            s1_n       <= '0;
            s1_dir     <= 1'b0;
            s1_arith   <= 1'b0;
            s1_illegal <= 1'b0;
            s1_dst     <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (accept) begin
                s1_valid <= 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (accept) begin
                s1_rs      <= rs_val;
                s1_n       <= dec_n;
                s1_dir     <= dec_dir;
                s1_arith   <= dec_arith;
                s1_illegal <= dec_illegal;
                s1_dst     <= dst;
            end
        end
    end

    // ---------------- stage 1 combinational ----------------
    logic        s1_oversize;
    logic        s1_n_zero;
    logic [4:0]  s1_n_m1;
    logic [31:0] s1_shl_m1;
    logic [31:0] s1_shr_m1;
    logic        s1_carry;

    assign s1_oversize = |s1_n[31:5];
    assign s1_n_zero   = (s1_n == 32'd0);

    // Shifting by n-1 puts the last bit shifted out at the edge of the word:
    // left -> bit 31 holds rs[32-n], right -> bit 0 holds rs[n-1].
    assign s1_n_m1   = s1_n[4:0] - 5'd1;
    assign s1_shl_m1 = s1_rs << s1_n_m1;
    assign s1_shr_m1 = s1_rs >> s1_n_m1;

    // NOTE: every signal written here gets a default first so no latch is
    // inferred on any path.
    always_comb begin
        s1_carry = 1'b0;
        if (!s1_illegal && !s1_oversize && !s1_n_zero) begin
            s1_carry = s1_dir ? s1_shl_m1[31] : s1_shr_m1[0];
        end
    end

    assign sh_in    = s1_rs;
    assign sh_dir   = s1_dir;
    assign sh_arith = s1_arith;

    always_comb begin
        sh_shamt = s1_n;
        if (s1_illegal) begin
            sh_shamt = 32'd0;
        end else if (s1_oversize) begin
            sh_shamt = 32'd31;
        end
    end

    // ---------------- stage 2 result selection ----------------
    logic [31:0] s2_result_d;
    logic        s2_zero_d;

    always_comb begin
        s2_result_d = sh_out;
        s2_zero_d   = 1'b0;
        if (s1_illegal) begin
            s2_result_d = s1_rs;
        end else begin
            // Oversize arithmetic right already yields 32 sign copies from
            // a shift by 31; the other modes must be forced to zero.
            if (s1_oversize && !s1_arith) begin
                s2_result_d = 32'd0;
            end
            s2_zero_d = (s2_result_d == 32'd0);
        end
    end

    // ---------------- stage 2 state ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            result     <= '0;
            out_dst    <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (s2_adv) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (s2_adv) begin
                result     <= s2_result_d;
                out_dst    <= s1_dst;
                zero_flag  <= s2_zero_d;
                carry_flag <= s1_carry;
                illegal    <= s1_illegal;
            end
        end
    end

endmodule

// File: tb/tb_shift_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_issue_unit
//
// Directed bench for shift_issue_unit. A behavioural model of the external
// combinational shifter closes the loop from sh_* back to sh_out. Inputs are
// driven 1 ns after the rising edge; outputs are sampled at #1 after the edge
// or at the falling edge.
// -----------------------------------------------------------------------------
module tb_shift_issue_unit;

    localparam logic [2:0] OP_SHLL  = 3'b000;
    localparam logic [2:0] OP_SHRL  = 3'b001;
    localparam logic [2:0] OP_SHRA  = 3'b010;
    localparam logic [2:0] OP_ILL   = 3'b011;
    localparam logic [2:0] OP_SHLLV = 3'b100;
    localparam logic [2:0] OP_SHRLV = 3'b101;
    localparam logic [2:0] OP_SHRAV = 3'b110;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  imm_shamt;
    logic [4:0]  dst;
    logic [31:0] sh_in;
    logic [31:0] sh_shamt;
    logic        sh_dir;
    logic        sh_arith;
    logic [31:0] sh_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  out_dst;
    logic        zero_flag;
    logic        carry_flag;
    logic        illegal;

    int n_vec  = 0;
    int n_miss = 0;

    shift_issue_unit dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .imm_shamt  (imm_shamt),
        .dst        (dst),
        .sh_in      (sh_in),
        .sh_shamt   (sh_shamt),
        .sh_dir     (sh_dir),
        .sh_arith   (sh_arith),
        .sh_out     (sh_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .out_dst    (out_dst),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .illegal    (illegal)
    );

    // Behavioural stand-in for the combinational shifter.
    always_comb begin
        if (sh_dir)
            sh_out = sh_in << sh_shamt[4:0];
        else if (sh_arith)
            sh_out = $unsigned($signed(sh_in) >>> sh_shamt[4:0]);
        else
            sh_out = sh_in >> sh_shamt[4:0];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request through an otherwise idle pipe with out_ready held high.
    task automatic run_one(input string tag, input logic [2:0] o, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [4:0] imm, input logic [4:0] d,
                           input logic [31:0] exp_shamt, input logic [31:0] exp_res,
                           input logic exp_zero, input logic exp_carry, input logic exp_ill);
        int wait_cnt;
        out_ready = 1'b1;
        wait_cnt  = 0;
        while (!in_ready && wait_cnt < 20) begin
            step();
            wait_cnt++;
        end
        check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
        op = o; rs_val = rs; rt_val = rt; imm_shamt = imm; dst = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_ov_early"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_shamt"}, sh_shamt, exp_shamt);
        step();
        check({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_dst"}, {27'b0, out_dst}, {27'b0, d});
        check({tag, "_zero"}, {31'b0, zero_flag}, {31'b0, exp_zero});
        check({tag, "_carry"}, {31'b0, carry_flag}, {31'b0, exp_carry});
        check({tag, "_ill"}, {31'b0, illegal}, {31'b0, exp_ill});
        step();
        check({tag, "_ov_clr"}, {31'b0, out_valid}, 32'd0);
    endtask

    // Stream table: op, rs, rt, imm, dst, expected result
    logic [2:0]  st_op  [4];
    logic [31:0] st_rs  [4];
    logic [31:0] st_rt  [4];
    logic [4:0]  st_imm [4];
    logic [4:0]  st_dst [4];
    logic [31:0] st_exp [4];

    initial begin
        st_op[0] = OP_SHLL;  st_rs[0] = 32'h0000_0001; st_rt[0] = 32'd0;  st_imm[0] = 5'd8;  st_dst[0] = 5'd3;  st_exp[0] = 32'h0000_0100;
        st_op[1] = OP_SHRL;  st_rs[1] = 32'hF000_0000; st_rt[1] = 32'd0;  st_imm[1] = 5'd28; st_dst[1] = 5'd7;  st_exp[1] = 32'h0000_000F;
        st_op[2] = OP_SHRAV; st_rs[2] = 32'h8000_0000; st_rt[2] = 32'd4;  st_imm[2] = 5'd0;  st_dst[2] = 5'd12; st_exp[2] = 32'hF800_0000;
        st_op[3] = OP_SHLLV; st_rs[3] = 32'h0000_00FF; st_rt[3] = 32'd16; st_imm[3] = 5'd0;  st_dst[3] = 5'd31; st_exp[3] = 32'h00FF_0000;
    end

    initial begin
        int tx;
        int rx;
        int cyc;
        logic        held;
        logic [31:0] held_res;
        logic        acc;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rs_val = '0; rt_val = '0; imm_shamt = '0; dst = '0;

        // ---- reset state ----
        #2;
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_sh_shamt", sh_shamt, 32'd0);
        check("rst_sh_in", sh_in, 32'd0);
        step();
        rst = 1'b1;
        #1;
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);
        step();

        // ---- single ops ----
        run_one("shll",  OP_SHLL,  32'd4567,      32'd0,  5'd4, 5'd1, 32'd4,  32'd73072,     1'b0, 1'b0, 1'b0);
        run_one("shra",  OP_SHRA,  32'hFFFF_FFC0, 32'd0,  5'd4, 5'd2, 32'd4,  32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        run_one("shrl",  OP_SHRL,  32'hFFFF_FFC0, 32'd0,  5'd4, 5'd3, 32'd4,  32'h0FFF_FFFC, 1'b0, 1'b0, 1'b0);
        run_one("shrav", OP_SHRAV, 32'hFFFF_FFC0, 32'd40, 5'd0, 5'd4, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_one("shrlv", OP_SHRLV, 32'hFFFF_FFC0, 32'd40, 5'd0, 5'd5, 32'd31, 32'd0,         1'b1, 1'b0, 1'b0);
        run_one("shllv_big", OP_SHLLV, 32'h0000_0001, 32'h1_0000, 5'd0, 5'd6, 32'd31, 32'd0, 1'b1, 1'b0, 1'b0);
        run_one("c_shllv", OP_SHLLV, 32'h8000_0001, 32'd1, 5'd0, 5'd8, 32'd1, 32'h0000_0002, 1'b0, 1'b1, 1'b0);
        run_one("c_shrl",  OP_SHRL,  32'h0000_0003, 32'd0, 5'd1, 5'd9, 32'd1, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        run_one("c_shra0", OP_SHRA,  32'h8000_0001, 32'd0, 5'd0, 5'd10, 32'd0, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
        run_one("ill",     OP_ILL,   32'h0000_1234, 32'd0, 5'd3, 5'd11, 32'd0, 32'h0000_1234, 1'b0, 1'b0, 1'b1);

        // ---- back-to-back stream, out_ready high ----
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                check("str_rdy", {31'b0, in_ready}, 32'd1);
                op = st_op[i]; rs_val = st_rs[i]; rt_val = st_rt[i];
                imm_shamt = st_imm[i]; dst = st_dst[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                check("str_ov", {31'b0, out_valid}, 32'd1);
                check("str_res", result, st_exp[i-1]);
                check("str_dst", {27'b0, out_dst}, {27'b0, st_dst[i-1]});
            end
        end
        in_valid = 1'b0;
        step();
        check("str_drain", {31'b0, out_valid}, 32'd0);

        // ---- stream with out_ready low for cycles 2..4 ----
        tx = 0; rx = 0; held = 1'b0; held_res = '0;
        for (cyc = 0; cyc < 20 && rx < 4; cyc++) begin
            out_ready = !(cyc >= 2 && cyc < 5);
            if (tx < 4) begin
                op = st_op[tx]; rs_val = st_rs[tx]; rt_val = st_rt[tx];
                imm_shamt = st_imm[tx]; dst = st_dst[tx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc == 2) check("bp_stall_rdy", {31'b0, in_ready}, 32'd0);
            if (cyc == 5) check("bp_resume_rdy", {31'b0, in_ready}, 32'd1);
            if (held) check("bp_stable", result, held_res);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check("bp_res", result, st_exp[rx]);
                check("bp_dst", {27'b0, out_dst}, {27'b0, st_dst[rx]});
                rx++;
            end
            held     = out_valid && !out_ready;
            held_res = result;
            step();
            if (acc) tx++;
        end
        in_valid = 1'b0;
        check("bp_rx", rx, 32'd4);
        check("bp_tx", tx, 32'd4);
        step();
        check("bp_drain", {31'b0, out_valid}, 32'd0);

        // ---- flush with both stages full and a request pending ----
        out_ready = 1'b0;
        op = OP_SHLL; rs_val = 32'd1; imm_shamt = 5'd1; dst = 5'd1; in_valid = 1'b1;
        step();
        op = OP_SHLL; rs_val = 32'd2; imm_shamt = 5'd1; dst = 5'd2;
        step();
        check("fl_full", {31'b0, out_valid}, 32'd1);
        op = OP_SHLL; rs_val = 32'd3; imm_shamt = 5'd1; dst = 5'd3;
        flush = 1'b1;
        #1;
        check("fl_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl_ov", {31'b0, out_valid}, 32'd0);
        step();
        check("fl_ov2", {31'b0, out_valid}, 32'd0);

        // ---- asynchronous reset mid-stream ----
        op = OP_SHLL; rs_val = 32'h55; imm_shamt = 5'd2; dst = 5'd4; in_valid = 1'b1; out_ready = 1'b0;
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_ov", {31'b0, out_valid}, 32'd0);
        check("arst_res", result, 32'd0);
        check("arst_dst", {27'b0, out_dst}, 32'd0);
        check("arst_sh_in", sh_in, 32'd0);
        check("arst_in_ready", {31'b0, in_ready}, 32'd0);
        step();
        rst = 1'b1;
        step();
        run_one("post_rst", OP_SHRL, 32'h8000_0000, 32'd0, 5'd31, 5'd20, 32'd31, 32'd1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
